// File: rtl/cnn_layer_accel_job_ctrl_pkg.sv
// Shared job-port types: descriptor layout, controller state encoding and
// the descriptor validity rule used by the controller, the loaders and the bench.
package cnn_layer_accel_job_pkg;

  typedef struct packed {
    logic [73:0] reserved;
    logic        actv;
    logic        master_quad;
    logic        cascade;
    logic [1:0]  conv_out_fmt;
    logic        upsample;
    logic [1:0]  padding;
    logic [1:0]  stride;
    logic [3:0]  kernel_size;
    logic [9:0]  num_kernels;
    logic [9:0]  depth;
    logic [9:0]  cols;
    logic [9:0]  rows;
  } job_params_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PARAM = 3'd1,
    ST_FREQ  = 3'd2,
    ST_FETCH = 3'd3,
    ST_RUN   = 3'd4,
    ST_CMPL  = 3'd5
  } job_state_t;

  function automatic logic job_params_check(input job_params_t p);
    logic dims_ok;
    logic ks_ok;
    logic st_ok;
    logic pad_ok;
    dims_ok = (p.rows != 10'd0) && (p.cols != 10'd0) &&
              (p.depth != 10'd0) && (p.num_kernels != 10'd0);
    ks_ok   = (p.kernel_size == 4'd1) || (p.kernel_size == 4'd3);
    st_ok   = (p.stride == 2'd1) || (p.stride == 2'd2);
    pad_ok  = ({2'b00, p.padding} <= (p.kernel_size >> 1));
    return dims_ok && ks_ok && st_ok && pad_ok;
  endfunction

endpackage

// File: rtl/cnn_layer_accel_job_ctrl_if.sv
// Host job handshake bundle; the host is the master, the quad controller the slave.
interface cnn_layer_accel_job_ctrl_if;

  logic         job_start;
  logic         job_accept;
  logic [127:0] job_parameters;
  logic         job_parameters_valid;
  logic         job_fetch_request;
  logic         job_fetch_ack;
  logic         job_fetch_complete;
  logic         job_complete;
  logic         job_complete_ack;

  modport master (
    output job_start, job_parameters, job_parameters_valid, job_fetch_ack, job_complete_ack,
    input  job_accept, job_fetch_request, job_fetch_complete, job_complete
  );

  modport slave (
    input  job_start, job_parameters, job_parameters_valid, job_fetch_ack, job_complete_ack,
    output job_accept, job_fetch_request, job_fetch_complete, job_complete
  );

endinterface

// File: rtl/cnn_layer_accel_job_watchdog.sv
// Ack watchdog: counts enabled cycles since the last clear and flags the cycle
// in which the C_ACK_TIMEOUT-th waiting cycle completes.
module cnn_layer_accel_job_watchdog #(
  parameter int C_ACK_TIMEOUT = 4096
) (
  input  logic clk_if,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(C_ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_TC  = CW'(C_ACK_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(C_ACK_TIMEOUT);
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  logic [CW-1:0] count;

  // Saturating cycle counter so the terminal flag fires only once per wait
  always_ff @(posedge clk_if) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != CNT_MAX)) begin
      count <= count + CNT_ONE;
    end else begin
      count <= count;
    end
  end

  assign expired = enable && !clear && (count == CNT_TC);

endmodule

// File: rtl/cnn_layer_accel_job_ctrl.sv
// Quad-side job controller: accepts a host job, validates and latches its
// descriptor, then sequences fetch, execute and completion handshakes.
module cnn_layer_accel_job_ctrl
  import cnn_layer_accel_job_pkg::*;
#(
  parameter int C_ACK_TIMEOUT = 4096,
  parameter int C_CNT_WIDTH   = 16
) (
  input  logic                        clk_if,
  input  logic                        rst,
  cnn_layer_accel_job_ctrl_if.slave   host,
  input  logic                        fetch_done,
  output logic                        exec_start,
  input  logic                        exec_done,
  output job_params_t                 cfg_params,
  output logic                        job_active,
  output logic                        param_err,
  output logic                        timeout_err,
  output logic [C_CNT_WIDTH-1:0]      jobs_done
);

  localparam logic [C_CNT_WIDTH-1:0] JOBS_ONE = {{(C_CNT_WIDTH-1){1'b0}}, 1'b1};

  job_state_t state;
  logic       waiting;
  logic       wd_expired;

  // Only the two host-ack waits are policed; any other state holds the count at zero
  assign waiting = (state == ST_FREQ) || (state == ST_CMPL);

  cnn_layer_accel_job_watchdog #(
    .C_ACK_TIMEOUT (C_ACK_TIMEOUT)
  ) u_watchdog (
    .clk_if  (clk_if),
    .rst     (rst),
    .clear   (!waiting),
    .enable  (waiting),
    .expired (wd_expired)
  );

  // Job sequencing FSM with all handshake outputs registered
  always_ff @(posedge clk_if) begin
    if (rst) begin
      state                   <= ST_IDLE;
      host.job_accept         <= 1'b0;
      host.job_fetch_request  <= 1'b0;
      host.job_fetch_complete <= 1'b0;
      host.job_complete       <= 1'b0;
      exec_start              <= 1'b0;
      cfg_params              <= '0;
      job_active              <= 1'b0;
      param_err               <= 1'b0;
      timeout_err             <= 1'b0;
      jobs_done               <= '0;
    end else begin
      host.job_accept         <= 1'b0;
      host.job_fetch_complete <= 1'b0;
      exec_start              <= 1'b0;
      if (wd_expired) begin
        timeout_err <= 1'b1;
      end else begin
        timeout_err <= timeout_err;
      end
      case (state)
        ST_IDLE: begin
          if (host.job_start) begin
            host.job_accept <= 1'b1;
            param_err       <= 1'b0;
            timeout_err     <= 1'b0;
            job_active      <= 1'b1;
            state           <= ST_PARAM;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_PARAM: begin
          if (host.job_parameters_valid) begin
            cfg_params <= job_params_t'(host.job_parameters);
            // An invalid descriptor still completes so the host sees the job retire
            if (job_params_check(job_params_t'(host.job_parameters))) begin
              host.job_fetch_request <= 1'b1;
              state                  <= ST_FREQ;
            end else begin
              param_err         <= 1'b1;
              host.job_complete <= 1'b1;
              state             <= ST_CMPL;
            end
          end else begin
            state <= ST_PARAM;
          end
        end
        ST_FREQ: begin
          if (host.job_fetch_ack) begin
            host.job_fetch_request <= 1'b0;
            state                  <= ST_FETCH;
          end else begin
            state <= ST_FREQ;
          end
        end
        ST_FETCH: begin
          if (fetch_done) begin
            host.job_fetch_complete <= 1'b1;
            exec_start              <= 1'b1;
            state                   <= ST_RUN;
          end else begin
            state <= ST_FETCH;
          end
        end
        ST_RUN: begin
          if (exec_done) begin
            host.job_complete <= 1'b1;
            state             <= ST_CMPL;
          end else begin
            state <= ST_RUN;
          end
        end
        ST_CMPL: begin
          if (host.job_complete_ack) begin
            host.job_complete <= 1'b0;
            jobs_done         <= jobs_done + JOBS_ONE;
            job_active        <= 1'b0;
            state             <= ST_IDLE;
          end else begin
            state <= ST_CMPL;
          end
        end
        default: begin
          host.job_fetch_request <= 1'b0;
          host.job_complete      <= 1'b0;
          job_active             <= 1'b0;
          state                  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_layer_accel_job_ctrl.sv
// Self-checking bench for the job controller: directed scenarios plus randomized
// jobs, checked against a phase-level protocol model.
module tb_cnn_layer_accel_job_ctrl;

  localparam int T  = 16;
  localparam int CW = 16;

  logic           clk_if = 1'b0;
  logic           rst;
  logic           fetch_done;
  logic           exec_done;
  logic           exec_start;
  logic           job_active;
  logic           param_err;
  logic           timeout_err;
  logic [127:0]   cfg_params;
  logic [CW-1:0]  jobs_done;

  cnn_layer_accel_job_ctrl_if host_if();

  cnn_layer_accel_job_ctrl #(
    .C_ACK_TIMEOUT (T),
    .C_CNT_WIDTH   (CW)
  ) dut (
    .clk_if      (clk_if),
    .rst         (rst),
    .host        (host_if),
    .fetch_done  (fetch_done),
    .exec_start  (exec_start),
    .exec_done   (exec_done),
    .cfg_params  (cfg_params),
    .job_active  (job_active),
    .param_err   (param_err),
    .timeout_err (timeout_err),
    .jobs_done   (jobs_done)
  );

  always #5 clk_if = ~clk_if;

  int   vectors     = 0;
  int   miscompares = 0;
  int   exp_jobs    = 0;
  logic exp_perr    = 1'b0;
  logic exp_to      = 1'b0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Control outputs packed as {accept, fetch_request, fetch_complete, exec_start, complete, active}
  task automatic check_outs(input string tag, input logic acc, input logic req, input logic fc,
                            input logic es, input logic cmp, input logic act);
    check_val({tag, "_ctl"},
              {host_if.job_accept, host_if.job_fetch_request, host_if.job_fetch_complete,
               exec_start, host_if.job_complete, job_active},
              {acc, req, fc, es, cmp, act});
    check_val({tag, "_err"}, {param_err, timeout_err}, {exp_perr, exp_to});
  endtask

  task automatic tick();
    @(posedge clk_if);
    #1;
  endtask

  function automatic bit desc_ok(input logic [127:0] d);
    int ks;
    int st;
    int pd;
    ks = int'(d[43:40]);
    st = int'(d[45:44]);
    pd = int'(d[47:46]);
    return (d[9:0] != 10'd0) && (d[19:10] != 10'd0) && (d[29:20] != 10'd0) &&
           (d[39:30] != 10'd0) && (ks == 1 || ks == 3) && (st == 1 || st == 2) &&
           (pd <= ks / 2);
  endfunction

  function automatic logic [127:0] gen_desc(input bit want_valid);
    logic [127:0] d;
    int ks;
    d = {$urandom, $urandom, $urandom, $urandom};
    ks = ($urandom_range(0, 1) == 0) ? 1 : 3;
    d[9:0]   = 10'($urandom_range(1, 1023));
    d[19:10] = 10'($urandom_range(1, 1023));
    d[29:20] = 10'($urandom_range(1, 1023));
    d[39:30] = 10'($urandom_range(1, 1023));
    d[43:40] = 4'(ks);
    d[45:44] = 2'($urandom_range(1, 2));
    d[47:46] = 2'($urandom_range(0, ks / 2));
    if (!want_valid) begin
      case ($urandom_range(0, 6))
        0: d[9:0]   = 10'd0;
        1: d[19:10] = 10'd0;
        2: d[29:20] = 10'd0;
        3: d[39:30] = 10'd0;
        4: d[43:40] = 4'($urandom_range(0, 7) * 2);
        5: d[45:44] = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'd3;
        default: d[47:46] = 2'($urandom_range(ks / 2 + 1, 3));
      endcase
    end
    return d;
  endfunction

  function automatic logic [127:0] nominal_desc(input int ks);
    logic [127:0] d;
    d = '0;
    d[9:0]   = 10'd19;
    d[19:10] = 10'd19;
    d[29:20] = 10'd8;
    d[39:30] = 10'd4;
    d[43:40] = 4'(ks);
    d[45:44] = 2'd1;
    d[47:46] = 2'd0;
    return d;
  endfunction

  task automatic spur_pulse(input bit hold);
    host_if.job_start            = 1'b1;
    host_if.job_parameters_valid = 1'b1;
    host_if.job_fetch_ack        = 1'b1;
    host_if.job_complete_ack     = 1'b1;
    tick();
    host_if.job_start            = hold;
    host_if.job_parameters_valid = 1'b0;
    host_if.job_fetch_ack        = 1'b0;
    host_if.job_complete_ack     = 1'b0;
  endtask

  task automatic run_job(input logic [127:0] d, input bit hold, input int pd, input int fa,
                         input int fd, input int ed, input int ca, input bit spur,
                         input bit dual, input bit abort_run);
    bit ok;
    int ed2;
    ok  = desc_ok(d);
    ed2 = (dual && ed == 0) ? 1 : ed;
    host_if.job_start = 1'b1;
    tick();
    exp_perr = 1'b0;
    exp_to   = 1'b0;
    check_outs("accept", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    host_if.job_start      = hold;
    host_if.job_parameters = d;
    for (int i = 0; i < pd; i++) begin
      tick();
      check_outs("param_wait", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    host_if.job_parameters_valid = 1'b1;
    tick();
    host_if.job_parameters_valid = 1'b0;
    host_if.job_parameters       = ~d;
    check_val("cfg_params", cfg_params, d);
    if (ok) begin
      check_outs("fetch_req", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int j = 1; j <= fa; j++) begin
        tick();
        exp_to = exp_to | (j >= T);
        check_outs("freq_wait", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      end
      host_if.job_fetch_ack = 1'b1;
      tick();
      host_if.job_fetch_ack = 1'b0;
      exp_to = exp_to | (fa + 1 >= T);
      check_outs("fetch_ack", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < fd; i++) begin
        if (spur) begin
          exec_done = 1'b1;
          spur_pulse(hold);
          exec_done = 1'b0;
        end else begin
          tick();
        end
        check_outs("fetch_wait", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      end
      fetch_done = 1'b1;
      exec_done  = dual;
      tick();
      fetch_done = 1'b0;
      exec_done  = 1'b0;
      check_outs("fetch_done", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < ed2; i++) begin
        if (spur) begin
          fetch_done = 1'b1;
          spur_pulse(hold);
          fetch_done = 1'b0;
        end else begin
          tick();
        end
        check_outs("run_wait", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      end
      if (abort_run) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_jobs = 0;
        exp_perr = 1'b0;
        exp_to   = 1'b0;
        check_outs("reset_run", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("reset_jobs", jobs_done, 128'd0);
        check_val("reset_cfg", cfg_params, 128'd0);
        return;
      end
      exec_done = 1'b1;
      tick();
      exec_done = 1'b0;
      check_outs("exec_done", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    end else begin
      exp_perr = 1'b1;
      check_outs("param_err", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    end
    for (int j = 1; j <= ca; j++) begin
      if (spur) begin
        fetch_done = 1'b1;
        exec_done  = 1'b1;
        host_if.job_fetch_ack = 1'b1;
        tick();
        fetch_done = 1'b0;
        exec_done  = 1'b0;
        host_if.job_fetch_ack = 1'b0;
      end else begin
        tick();
      end
      exp_to = exp_to | (j >= T);
      check_outs("cmpl_wait", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    end
    host_if.job_complete_ack = 1'b1;
    tick();
    host_if.job_complete_ack = 1'b0;
    exp_to = exp_to | (ca + 1 >= T);
    exp_jobs++;
    check_outs("cmpl_ack", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_val("jobs_done", jobs_done, 128'(exp_jobs[CW-1:0]));
    check_val("cfg_hold", cfg_params, d);
  endtask

  initial begin
    rst                          = 1'b1;
    fetch_done                   = 1'b0;
    exec_done                    = 1'b0;
    host_if.job_start            = 1'b0;
    host_if.job_parameters       = '0;
    host_if.job_parameters_valid = 1'b0;
    host_if.job_fetch_ack        = 1'b0;
    host_if.job_complete_ack     = 1'b0;
    tick();
    tick();
    check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_val("reset_jobs", jobs_done, 128'd0);
    check_val("reset_cfg", cfg_params, 128'd0);
    rst = 1'b0;
    tick();
    check_outs("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // nominal, invalid kernel, ack timeout, spurious inputs during fetch
    run_job(nominal_desc(3), 1'b0, 0, 1, 2, 2, 1, 1'b0, 1'b0, 1'b0);
    run_job(nominal_desc(2), 1'b0, 1, 0, 0, 0, 2, 1'b0, 1'b0, 1'b0);
    run_job(nominal_desc(3), 1'b0, 0, 20, 1, 1, 1, 1'b0, 1'b0, 1'b0);
    run_job(gen_desc(1'b1), 1'b0, 0, 2, 3, 1, 1, 1'b1, 1'b0, 1'b0);
    // same-cycle fetch_done/exec_done, then abandon a job mid-run
    run_job(gen_desc(1'b1), 1'b0, 0, 0, 0, 2, 0, 1'b0, 1'b1, 1'b0);
    run_job(gen_desc(1'b1), 1'b0, 0, 1, 1, 3, 1, 1'b0, 1'b0, 1'b1);
    run_job(nominal_desc(1), 1'b0, 0, 1, 1, 1, 1, 1'b0, 1'b0, 1'b0);

    for (int k = 0; k < 3; k++) begin
      run_job(gen_desc(1'b1), 1'b1, 0, $urandom_range(0, 2), $urandom_range(0, 2),
              $urandom_range(0, 2), $urandom_range(0, 2), 1'b0, 1'b0, 1'b0);
    end
    host_if.job_start = 1'b0;
    tick();
    check_outs("b2b_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int k = 0; k < 30; k++) begin
      run_job(gen_desc($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
              $urandom_range(0, 2),
              ($urandom_range(0, 7) == 0) ? $urandom_range(14, 20) : $urandom_range(0, 4),
              $urandom_range(0, 4), $urandom_range(0, 4),
              ($urandom_range(0, 7) == 0) ? $urandom_range(14, 20) : $urandom_range(0, 4),
              $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, 1'b0);
    end
    host_if.job_start = 1'b0;
    tick();
    check_outs("final_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
